speed_test_scheduler: RTL and testbench

SPEED_TEST_SCHEDULER -- requirements
Module: speed_test_scheduler

---
 rtl/speed_test_pkg.sv | 39 +++
 rtl/speed_test_port_seq.sv | 91 +++++++++
 rtl/speed_test_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_speed_test_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_test_pkg.sv
// Shared register offsets, port FSM states and address-decode record for the speed test scheduler.
// Word-count helpers size the per-port config and result windows.
package speed_test_pkg;

  localparam logic [5:0] REG_START      = 6'h00;
  localparam logic [5:0] REG_STOP       = 6'h04;
  localparam logic [5:0] REG_STATUS     = 6'h08;
  localparam logic [5:0] REG_DONE_CLR   = 6'h0C;
  localparam logic [5:0] REG_DURATION   = 6'h10;
  localparam logic [5:0] REG_CLOCK_FREQ = 6'h14;

  localparam int RES_WORD_BASE = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } port_state_e;

  typedef struct packed {
    logic       glob;
    logic       cfg;
    logic       res;
    logic [3:0] port;
    logic [3:0] word;
    logic [5:0] off;
  } reg_dec_t;

  function automatic int words_for(input int bits);
    return (bits + 31) / 32;
  endfunction

  localparam int DEF_CONFIG_WIDTH = 174;
  localparam int DEF_RESULT_WIDTH = 128;
  localparam int CFG_WORDS = words_for(DEF_CONFIG_WIDTH);
  localparam int RES_WORDS = words_for(DEF_RESULT_WIDTH);

endpackage

// File: rtl/speed_test_port_seq.sv
// One tester port: IDLE/ARM/RUN/DRAIN sequencer, run-length counter, done flag and result shadow.
// start/stop are registered one-cycle pulses; ARM and DRAIN stall on the port's ready inputs.
module speed_test_port_seq
  import speed_test_pkg::*;
#(
  parameter int RESULT_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_req,
  input  logic                    stop_req,
  input  logic                    done_clr,
  input  logic                    gen_ready,
  input  logic                    check_ready,
  input  logic [RESULT_WIDTH-1:0] check_results,
  input  logic [31:0]             duration,
  output logic                    start,
  output logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] result
);

  port_state_e state, state_nxt;
  logic [31:0] cnt;
  logic        start_nxt;
  logic        stop_nxt;
  logic        capture;
  logic        dur_hit;

  // Compare at 33 bits so a DURATION shrunk below the count still fires.
  assign dur_hit = (duration != 32'd0) && (({1'b0, cnt} + 33'd1) >= {1'b0, duration});
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (stop_req) begin
          state_nxt = ST_IDLE;
        end else if (gen_ready && check_ready) begin
          state_nxt = ST_RUN;
          start_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_req || dur_hit) begin
          state_nxt = ST_DRAIN;
          stop_nxt  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (check_ready) begin
          state_nxt = ST_IDLE;
          capture   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      start  <= 1'b0;
      stop   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      start <= start_nxt;
      stop  <= stop_nxt;
      if (start_nxt) begin
        cnt <= '0;
      end else if (state == ST_RUN) begin
        cnt <= cnt + 32'd1;
      end
      // A capture in the same cycle as a clear keeps the bit set.
      done <= capture | (done & ~done_clr);
      if (capture) result <= check_results;
    end
  end

endmodule

// File: rtl/speed_test_scheduler.sv
// AXI4-Lite controlled scheduler that starts, times and stops TEST_PORT_NUM tester ports.
// Register writes/reads complete in 2 cycles; B/R channels hold until BREADY/RREADY.
module speed_test_scheduler
  import speed_test_pkg::*;
#(
  parameter int TEST_PORT_NUM      = 4,
  parameter int CLOCK_FREQ         = 125000000,
  parameter int CONFIG_WIDTH       = 174,
  parameter int RESULT_WIDTH       = 128,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                            S_AXI_AWPROT,
  input  logic                                  S_AXI_AWVALID,
  output logic                                  S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
  input  logic                                  S_AXI_WVALID,
  output logic                                  S_AXI_WREADY,
  output logic [1:0]                            S_AXI_BRESP,
  output logic                                  S_AXI_BVALID,
  input  logic                                  S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                            S_AXI_ARPROT,
  input  logic                                  S_AXI_ARVALID,
  output logic                                  S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                            S_AXI_RRESP,
  output logic                                  S_AXI_RVALID,
  input  logic                                  S_AXI_RREADY,
  input  logic [TEST_PORT_NUM-1:0]              gen_ready,
  input  logic [TEST_PORT_NUM-1:0]              check_ready,
  input  logic [TEST_PORT_NUM*RESULT_WIDTH-1:0] check_results,
  output logic [TEST_PORT_NUM-1:0]              start,
  output logic [TEST_PORT_NUM-1:0]              stop,
  output logic [TEST_PORT_NUM*CONFIG_WIDTH-1:0] port_config,
  output logic                                  done_irq
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int CfgWords = words_for(CONFIG_WIDTH);
  localparam int ResWords = words_for(RESULT_WIDTH);

  logic                    awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]              bresp_q;
  logic [31:0]             rdata_q, rd_val, duration_q, wbits;
  logic                    wr_en, rd_en, wr_busy;
  reg_dec_t                wdec, rdec;
  logic [TEST_PORT_NUM-1:0] start_req, stop_req, done_clr, busy, done;
  logic [CONFIG_WIDTH-1:0] cfg_q    [TEST_PORT_NUM];
  logic [RESULT_WIDTH-1:0] result_q [TEST_PORT_NUM];
  logic                    unused_ok;

  function automatic reg_dec_t decode(input logic [AW-1:0] addr);
    reg_dec_t d;
    int       win;
    d      = '0;
    win    = int'(addr[AW-1:6]);
    d.off  = addr[5:0];
    d.word = addr[5:2];
    if (win == 0) begin
      d.glob = 1'b1;
    end else if (win <= TEST_PORT_NUM) begin
      d.port = 4'(win - 1);
      d.cfg  = !addr[5] && (int'(addr[4:2]) < CfgWords);
      d.res  = (addr[5:4] == 2'b10) && (int'(addr[3:2]) < ResWords);
    end
    return d;
  endfunction

  assign wdec  = decode(S_AXI_AWADDR);
  assign rdec  = decode(S_AXI_ARADDR);
  assign wr_en = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en = arready_q && S_AXI_ARVALID;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wbits     = '0;
    wr_busy   = 1'b0;
    start_req = '0;
    stop_req  = '0;
    done_clr  = '0;
    for (int b = 0; b < 32; b++) wbits[b] = S_AXI_WSTRB[b/8];
    for (int p = 0; p < TEST_PORT_NUM; p++) begin
      if (wdec.cfg && wdec.port == 4'(p) && busy[p]) wr_busy = 1'b1;
      if (wr_en && wdec.glob) begin
        start_req[p] = (wdec.off == REG_START)    && S_AXI_WDATA[p] && wbits[p];
        stop_req[p]  = (wdec.off == REG_STOP)     && S_AXI_WDATA[p] && wbits[p];
        done_clr[p]  = (wdec.off == REG_DONE_CLR) && S_AXI_WDATA[p] && wbits[p];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (rdec.glob) begin
      case (rdec.off)
        REG_STATUS:     rd_val = {16'(done), 16'(busy)};
        REG_DURATION:   rd_val = duration_q;
        REG_CLOCK_FREQ: rd_val = 32'(CLOCK_FREQ);
        default:        rd_val = '0;
      endcase
    end
    for (int p = 0; p < TEST_PORT_NUM; p++) begin
      if (rdec.port == 4'(p)) begin
        if (rdec.cfg) begin
          for (int i = 0; i < CONFIG_WIDTH; i++)
            if (i / 32 == int'(rdec.word)) rd_val[i%32] = cfg_q[p][i];
        end
        if (rdec.res) begin
          for (int i = 0; i < RESULT_WIDTH; i++)
            if (i / 32 == int'(rdec.word) - RES_WORD_BASE) rd_val[i%32] = result_q[p][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      duration_q <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_busy ? 2'b10 : 2'b00;
        if (wdec.glob && wdec.off == REG_DURATION)
          duration_q <= (duration_q & ~wbits) | (S_AXI_WDATA & wbits);
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Config of a running port is frozen; the write is answered with SLVERR above.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < TEST_PORT_NUM; p++) cfg_q[p] <= '0;
    end else if (wr_en && wdec.cfg) begin
      for (int p = 0; p < TEST_PORT_NUM; p++) begin
        if (wdec.port == 4'(p) && !busy[p]) begin
          for (int i = 0; i < CONFIG_WIDTH; i++)
            if (i / 32 == int'(wdec.word) && wbits[i%32]) cfg_q[p][i] <= S_AXI_WDATA[i%32];
        end
      end
    end
  end

  for (genvar p = 0; p < TEST_PORT_NUM; p++) begin : g_port
    speed_test_port_seq #(
      .RESULT_WIDTH(RESULT_WIDTH)
    ) u_seq (
      .clk          (clk),
      .rst          (rst),
      .start_req    (start_req[p]),
      .stop_req     (stop_req[p]),
      .done_clr     (done_clr[p]),
      .gen_ready    (gen_ready[p]),
      .check_ready  (check_ready[p]),
      .check_results(check_results[p*RESULT_WIDTH +: RESULT_WIDTH]),
      .duration     (duration_q),
      .start        (start[p]),
      .stop         (stop[p]),
      .busy         (busy[p]),
      .done         (done[p]),
      .result       (result_q[p])
    );
    assign port_config[p*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg_q[p];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign done_irq      = |done;

endmodule

// File: tb/tb_speed_test_scheduler.sv
// Directed bench for speed_test_scheduler: register table plus hand-written run/stop/drain/reset sequences.
module tb_speed_test_scheduler;

  localparam int N  = 4;
  localparam int CW = 174;
  localparam int RW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]    awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic          bready = 1'b1, rready = 1'b1;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [N-1:0]  gen_ready = '1, check_ready = '1;
  logic [N*RW-1:0] check_results = '0;
  logic [N-1:0]  start, stop;
  logic [N*CW-1:0] port_config;
  logic          done_irq;

  speed_test_scheduler dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .gen_ready(gen_ready), .check_ready(check_ready), .check_results(check_results),
    .start(start), .stop(stop), .port_config(port_config), .done_irq(done_irq)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cyc = 0;
  int start_cnt [N] = '{default: 0};
  int stop_cnt  [N] = '{default: 0};
  int start_cyc [N] = '{default: 0};
  int stop_cyc  [N] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int p = 0; p < N; p++) begin
      if (start[p]) begin start_cnt[p]++; start_cyc[p] = cyc; end
      if (stop[p])  begin stop_cnt[p]++;  stop_cyc[p]  = cyc; end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out, required a response", name);
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int n = 0;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) begin
      timeout("axi_write_aw");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wr_cyc = cyc;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin timeout("axi_write_b"); return; end
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] data);
    int n = 0;
    data = 'x;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) begin
      timeout("axi_read_ar");
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin timeout("axi_read_r"); return; end
    data = rdata;
    @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, 4'hF, r);
  endtask

  task automatic rd_check(input string name, input logic [9:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic wait_start(input int p, input int base);
    int n = 0;
    while (start_cnt[p] == base && n < 1000) begin @(posedge clk); n++; end
    if (start_cnt[p] == base) timeout($sformatf("wait_start_p%0d", p));
  endtask

  task automatic wait_stop(input int p, input int base);
    int n = 0;
    while (stop_cnt[p] == base && n < 1000) begin @(posedge clk); n++; end
    if (stop_cnt[p] == base) timeout($sformatf("wait_stop_p%0d", p));
  endtask

  typedef struct {
    string       name;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd_exp;
    logic [1:0]  resp_exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    int ws, s0, s1, s2, t2, s3;

    vecs[0]  = '{"dur_full",      10'h010, 32'h12345678, 4'hF, 32'h12345678, 2'b00};
    vecs[1]  = '{"dur_strb_lo",   10'h010, 32'hAABBCCDD, 4'h3, 32'h1234CCDD, 2'b00};
    vecs[2]  = '{"dur_strb_hi",   10'h010, 32'hEE000000, 4'h8, 32'hEE34CCDD, 2'b00};
    vecs[3]  = '{"clock_freq_ro", 10'h014, 32'h00000000, 4'hF, 32'h07735940, 2'b00};
    vecs[4]  = '{"unmapped_glob", 10'h018, 32'hFFFFFFFF, 4'hF, 32'h00000000, 2'b00};
    vecs[5]  = '{"p0_cfg_w0",     10'h040, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2'b00};
    vecs[6]  = '{"p0_cfg_w5_top", 10'h054, 32'hFFFFFFFF, 4'hF, 32'h00003FFF, 2'b00};
    vecs[7]  = '{"p0_cfg_w6",     10'h058, 32'hFFFFFFFF, 4'hF, 32'h00000000, 2'b00};
    vecs[8]  = '{"p3_cfg_w1_strb",10'h104, 32'h01020304, 4'h5, 32'h00020004, 2'b00};
    vecs[9]  = '{"window_oob",    10'h140, 32'h00000055, 4'hF, 32'h00000000, 2'b00};
    vecs[10] = '{"p0_res_ro",     10'h060, 32'h00000001, 4'hF, 32'h00000000, 2'b00};
    vecs[11] = '{"start_no_strb", 10'h000, 32'h00000001, 4'h0, 32'h00000000, 2'b00};
    vecs[12] = '{"status_ro",     10'h008, 32'h0000FFFF, 4'hF, 32'h00000000, 2'b00};

    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_pulses",  64'({start, stop, done_irq}), 64'd0);
    check("rst_config_zero", 64'(port_config == '0), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
      check({vecs[i].name, "_bresp"}, 64'(resp), 64'(vecs[i].resp_exp));
      axi_read(vecs[i].addr, d);
      check({vecs[i].name, "_rdata"}, 64'(d), 64'(vecs[i].rd_exp));
    end
    check("cfg_out_p0_w0",   64'(port_config[31:0]), 64'hDEADBEEF);
    check("cfg_out_p0_top",  64'(port_config[173:160]), 64'h3FFF);
    check("cfg_out_p3_w1",   64'(port_config[3*CW+32 +: 32]), 64'h00020004);
    check("cfg_out_p1_zero", 64'(port_config[1*CW +: CW] == '0), 64'd1);
    check("no_start_yet",    64'(start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3]), 64'd0);

    // Timed run: DURATION=100 on port 0.
    check_results[0 +: RW] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    wr(10'h010, 32'd100);
    s0 = start_cnt[0]; t2 = stop_cnt[0];
    wr(10'h000, 32'h1);
    ws = wr_cyc;
    wait_stop(0, t2);
    check("dur_start_after_arm", 64'(start_cyc[0] - ws), 64'd1);
    check("dur_run_length",      64'(stop_cyc[0] - start_cyc[0]), 64'd100);
    check("dur_start_count",     64'(start_cnt[0] - s0), 64'd1);
    repeat (3) @(posedge clk);
    check("dur_stop_count", 64'(stop_cnt[0] - t2), 64'd1);
    rd_check("dur_status", 10'h008, 32'h0001_0000);
    check("dur_irq", 64'(done_irq), 64'd1);
    wr(10'h00C, 32'h1);
    check("done_clr_irq", 64'(done_irq), 64'd0);

    // Manual stop of port 1 only; port 0 keeps running.
    wr(10'h010, 32'd0);
    s0 = stop_cnt[0]; s1 = stop_cnt[1]; s2 = start_cnt[0]; s3 = start_cnt[1];
    wr(10'h000, 32'h3);
    repeat (50) @(posedge clk);
    wr(10'h004, 32'h2);
    repeat (5) @(posedge clk);
    check("man_start_both", 64'((start_cnt[0] - s2) + (start_cnt[1] - s3)), 64'd2);
    check("man_stop_p1",    64'(stop_cnt[1] - s1), 64'd1);
    check("man_stop_p0",    64'(stop_cnt[0] - s0), 64'd0);
    rd_check("man_status", 10'h008, 32'h0002_0001);

    // Config writes: busy port rejected, idle port accepted.
    axi_write(10'h040, 32'h11111111, 4'hF, resp);
    check("busy_cfg_bresp", 64'(resp), 64'h2);
    check("busy_cfg_keep",  64'(port_config[31:0]), 64'hDEADBEEF);
    axi_write(10'h080, 32'h0000CAFE, 4'hF, resp);
    check("idle_cfg_bresp", 64'(resp), 64'h0);
    check("idle_cfg_out",   64'(port_config[CW +: 32]), 64'h0000CAFE);
    wr(10'h004, 32'h1);
    repeat (5) @(posedge clk);
    wr(10'h00C, 32'h3);
    rd_check("clr_status", 10'h008, 32'h0);

    // Delayed drain: capture waits for check_ready, shadow holds afterwards.
    check_results[0 +: RW] = 128'hA5A5_0004_A5A5_0003_A5A5_0002_A5A5_0001;
    wr(10'h010, 32'd20);
    s0 = start_cnt[0]; t2 = stop_cnt[0];
    wr(10'h000, 32'h1);
    wait_start(0, s0);
    check_ready[0] = 1'b0;
    wait_stop(0, t2);
    repeat (10) @(posedge clk);
    rd_check("drain_wait_status", 10'h008, 32'h0000_0001);
    check_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    check_results[0 +: RW] = '0;
    repeat (2) @(posedge clk);
    rd_check("res_w0", 10'h060, 32'hA5A50001);
    rd_check("res_w1", 10'h064, 32'hA5A50002);
    rd_check("res_w2", 10'h068, 32'hA5A50003);
    rd_check("res_w3", 10'h06C, 32'hA5A50004);
    rd_check("drain_done_status", 10'h008, 32'h0001_0000);
    wr(10'h00C, 32'h1);

    // Abort from ARM: no pulses, no done.
    gen_ready[2] = 1'b0;
    s2 = start_cnt[2]; t2 = stop_cnt[2];
    wr(10'h000, 32'h4);
    repeat (5) @(posedge clk);
    rd_check("arm_status", 10'h008, 32'h0000_0004);
    wr(10'h004, 32'h4);
    repeat (3) @(posedge clk);
    rd_check("arm_abort_status", 10'h008, 32'h0);
    check("arm_abort_pulses", 64'((start_cnt[2] - s2) + (stop_cnt[2] - t2)), 64'd0);
    check("arm_abort_irq", 64'(done_irq), 64'd0);
    gen_ready[2] = 1'b1;

    // Shrinking DURATION below the running count stops on the next cycle.
    wr(10'h010, 32'd0);
    s0 = start_cnt[0]; t2 = stop_cnt[0];
    wr(10'h000, 32'h1);
    wait_start(0, s0);
    repeat (30) @(posedge clk);
    wr(10'h010, 32'd10);
    ws = wr_cyc;
    wait_stop(0, t2);
    check("dur_shrink_stop", 64'(stop_cyc[0] - ws), 64'd1);
    repeat (3) @(posedge clk);
    wr(10'h00C, 32'h1);

    // Reset during RUN: no stop pulse, everything cleared.
    wr(10'h010, 32'd500);
    s3 = start_cnt[3]; t2 = stop_cnt[3];
    wr(10'h000, 32'h8);
    wait_start(3, s3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    check("rst_run_no_stop", 64'(stop_cnt[3] - t2), 64'd0);
    rd_check("rst_run_status",   10'h008, 32'h0);
    rd_check("rst_run_duration", 10'h010, 32'h0);
    check("rst_run_config", 64'(port_config == '0), 64'd1);
    check("rst_run_irq", 64'(done_irq), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
